// File: rtl/string_search_pkg.sv
// Shared types and helpers for the string search processor.
package string_search_pkg;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_NEEDLE,
    ST_HAY,
    ST_DRAIN,
    ST_EMIT
  } state_t;

  // Widest supported result; callers slice the low COUNT_WIDTH bits.
  localparam int unsigned ERROR_COUNT_MAX_W = 256;
  localparam logic [ERROR_COUNT_MAX_W-1:0] ERROR_COUNT = '1;

  function automatic logic [7:0] fold_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= 8'h41 && b <= 8'h5A) r = b | 8'h20;
    return r;
  endfunction

endpackage

// File: rtl/string_search_window.sv
// Haystack shift window, needle store and length-masked parallel comparator.
module string_search_window
  import string_search_pkg::*;
#(
  parameter  int unsigned MAX_NEEDLE_SIZE = 16,
  localparam int unsigned LW = $clog2(MAX_NEEDLE_SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          needle_shift,
  input  logic          hay_shift,
  input  logic [LW-1:0] needle_len,
  input  logic [7:0]    data,
  output logic          match
);

  logic [MAX_NEEDLE_SIZE-1:0][7:0] needle;
  logic [MAX_NEEDLE_SIZE-1:0][7:0] window;
  logic [MAX_NEEDLE_SIZE-1:0][7:0] window_nxt;
  logic [LW-1:0]                   seen;
  logic [LW-1:0]                   seen_nxt;
  logic                            all_eq;

  always_comb begin
    window_nxt[0] = data;
    for (int unsigned j = 1; j < MAX_NEEDLE_SIZE; j++) window_nxt[j] = window[j-1];
  end

  always_comb begin
    seen_nxt = (seen == LW'(MAX_NEEDLE_SIZE)) ? seen : seen + LW'(1);
  end

  // Needle is kept as a shift register too, so after N bytes needle[j] holds
  // needle byte N-1-j and lines up index-for-index with window_nxt[j].
  always_comb begin
    all_eq = 1'b1;
    for (int unsigned j = 0; j < MAX_NEEDLE_SIZE; j++) begin
      if (LW'(j) < needle_len && window_nxt[j] != needle[j]) all_eq = 1'b0;
    end
  end

  always_comb begin
    match = hay_shift && (seen_nxt >= needle_len) && all_eq;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      needle <= '0;
      window <= '0;
      seen   <= '0;
    end else begin
      if (needle_shift) begin
        needle[0] <= data;
        for (int unsigned j = 1; j < MAX_NEEDLE_SIZE; j++) needle[j] <= needle[j-1];
      end
      if (hay_shift) window <= window_nxt;
      if (clear) begin
        seen <= '0;
      end else if (hay_shift) begin
        seen <= seen_nxt;
      end
    end
  end

endmodule

// File: rtl/string_search_processor.sv
// Framed substring counter with MSB-first multi-byte result output.
// Optional macro STRING_SEARCH_CASE_FOLD_EN enables ASCII case-insensitive matching.
module string_search_processor
  import string_search_pkg::*;
#(
  parameter int unsigned MAX_NEEDLE_SIZE = 16,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int unsigned COUNT_BYTES = COUNT_WIDTH / 8;
  localparam int unsigned LW = $clog2(MAX_NEEDLE_SIZE + 1);
  localparam int unsigned KW = (COUNT_BYTES > 1) ? $clog2(COUNT_BYTES) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_SAT = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

  state_t                 state;
  state_t                 state_nxt;
  logic [LW-1:0]          n_len;
  logic [LW-1:0]          idx;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] result;
  logic                   err;
  logic [KW-1:0]          k;
  logic [7:0]             byte_in;
  logic [7:0]             out_byte;
  logic                   accept;
  logic                   out_fire;
  logic                   last_out;
  logic                   len_ok;
  logic                   match;

`ifdef STRING_SEARCH_CASE_FOLD_EN
  assign byte_in = fold_byte(in_data);
`else
  assign byte_in = in_data;
`endif

  assign in_ready = enable && !reset && (state != ST_EMIT);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_out = out_fire && out_last;
  assign len_ok   = (in_data != '0) && (32'(in_data) <= MAX_NEEDLE_SIZE);

  string_search_window #(
    .MAX_NEEDLE_SIZE(MAX_NEEDLE_SIZE)
  ) u_window (
    .clock       (clock),
    .reset       (reset),
    .clear       (last_out),
    .needle_shift(accept && state == ST_NEEDLE),
    .hay_shift   (accept && state == ST_HAY),
    .needle_len  (n_len),
    .data        (byte_in),
    .match       (match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_LEN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LEN: begin
        if (accept) begin
          if (in_last)     state_nxt = ST_EMIT;
          else if (len_ok) state_nxt = ST_NEEDLE;
          else             state_nxt = ST_DRAIN;
        end
      end
      ST_NEEDLE: begin
        if (accept) begin
          if (in_last)                      state_nxt = ST_EMIT;
          else if (idx == n_len - LW'(1))   state_nxt = ST_HAY;
        end
      end
      ST_HAY, ST_DRAIN: begin
        if (accept && in_last) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (last_out) state_nxt = ST_LEN;
      end
      default: state_nxt = ST_LEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_len <= '0;
      idx   <= '0;
      count <= '0;
      err   <= 1'b0;
      k     <= '0;
    end else begin
      if (state == ST_LEN && accept) begin
        n_len <= LW'(in_data);
        err   <= !len_ok;
      end
      if (state == ST_NEEDLE && accept) idx <= idx + LW'(1);
      if (match && count != COUNT_SAT) count <= count + 1'b1;
      if (out_fire) k <= k + KW'(1);
      if (last_out) begin
        count <= '0;
        err   <= 1'b0;
        idx   <= '0;
        k     <= '0;
      end
    end
  end

  assign result = err ? ERROR_COUNT[COUNT_WIDTH-1:0] : count;

  always_comb begin
    out_byte = '0;
    for (int unsigned b = 0; b < COUNT_BYTES; b++) begin
      if (k == KW'(COUNT_BYTES - 1 - b)) out_byte = result[b*8 +: 8];
    end
  end

  assign out_valid = enable && (state == ST_EMIT);
  assign out_data  = out_valid ? out_byte : '0;
  assign out_last  = out_valid && (k == KW'(COUNT_BYTES - 1));

endmodule

// File: tb/tb_string_search_processor.sv
// Randomised and directed bench for string_search_processor against a queue-based reference.
module tb_string_search_processor;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic       sel;

  logic       a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic       b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_data;
  logic       rdy, ov, ol;
  logic [7:0] od;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_out_ready = out_ready & sel;
  assign rdy = sel ? b_in_ready  : a_in_ready;
  assign ov  = sel ? b_out_valid : a_out_valid;
  assign ol  = sel ? b_out_last  : a_out_last;
  assign od  = sel ? b_out_data  : a_out_data;

  string_search_processor #(.MAX_NEEDLE_SIZE(16), .COUNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_data(in_data), .in_valid(a_in_valid), .in_last(in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last), .out_ready(a_out_ready)
  );

  string_search_processor #(.MAX_NEEDLE_SIZE(4), .COUNT_WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .enable(enable),
    .in_data(in_data), .in_valid(b_in_valid), .in_last(in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_fold(input logic [7:0] b);
`ifdef STRING_SEARCH_CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'd32;
`endif
    return b;
  endfunction

  // Reference: parse the frame and count every alignment of the needle in the haystack.
  function automatic logic [63:0] ref_result(input logic [7:0] f[$], input int max_n, input int w);
    int n;
    logic [63:0] c;
    logic [63:0] sat;
    logic [7:0] nd[$];
    logic [7:0] hs[$];
    bit hit;
    c = 0;
    sat = (64'd1 << w) - 2;
    n = int'(f[0]);
    if (n < 1 || n > max_n) return (64'd1 << w) - 1;
    for (int p = 1; p < f.size(); p++) begin
      if (p <= n) nd.push_back(tb_fold(f[p]));
      else        hs.push_back(tb_fold(f[p]));
    end
    if (nd.size() < n) return 0;
    for (int s = 0; s + n <= hs.size(); s++) begin
      hit = 1;
      for (int j = 0; j < n; j++) if (hs[s+j] != nd[j]) hit = 0;
      if (hit && c < sat) c++;
    end
    return c;
  endfunction

  function automatic void make_frame(output logic [7:0] f[$], input int n, input string nd, input string hs);
    f = {};
    f.push_back(8'(n));
    for (int i = 0; i < nd.len(); i++) f.push_back(nd[i]);
    for (int i = 0; i < hs.len(); i++) f.push_back(hs[i]);
  endfunction

  task automatic send_bytes(input logic [7:0] f[$], input bit terminate, input bit gaps);
    int cyc;
    for (int p = 0; p < f.size(); p++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      in_data  = f[p];
      in_last  = terminate && (p == f.size() - 1);
      in_valid = 1'b1;
      cyc = 0;
      while (!rdy && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
      if (!rdy) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (terminate) begin
      check("first_out_latency", ov, 1);
      check("in_ready_in_emit", rdy, 0);
    end
  endtask

  task automatic recv_result(input logic [63:0] exp, input int nbytes, input int hold);
    int cyc;
    logic [7:0] eb;
    for (int k = 0; k < nbytes; k++) begin
      eb = 8'(exp >> (8 * (nbytes - 1 - k)));
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", ov, 1);
        check("hold_data", od, eb);
        check("hold_in_ready", rdy, 0);
        @(negedge clock);
      end
      out_ready = 1'b1;
      cyc = 0;
      while (!ov && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
      check("out_byte", od, eb);
      check("out_last", ol, (k == nbytes - 1));
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
    end
    check("out_valid_after_frame", ov, 0);
    check("next_frame_ready", rdy, 1);
  endtask

  task automatic run(input logic [7:0] f[$], input bit s, input int hold, input bit gaps);
    logic [63:0] exp;
    sel = s;
    exp = ref_result(f, s ? 4 : 16, s ? 8 : 16);
    send_bytes(f, 1'b1, gaps);
    recv_result(exp, s ? 1 : 2, hold);
  endtask

  task automatic rand_frame(output logic [7:0] f[$], input int max_n);
    int r;
    int n;
    int len;
    logic [7:0] alpha [4];
    alpha[0] = 8'h61; alpha[1] = 8'h62; alpha[2] = 8'h41; alpha[3] = 8'h42;
    r = $urandom_range(0, 9);
    if (r == 0)      n = 0;
    else if (r == 1) n = max_n + 1 + $urandom_range(0, 3);
    else if (r < 7)  n = $urandom_range(1, 3);
    else             n = $urandom_range(1, max_n);
    f = {};
    f.push_back(8'(n));
    len = (r == 9) ? $urandom_range(0, 3) : n + $urandom_range(0, 30);
    for (int i = 0; i < len; i++) f.push_back(alpha[$urandom_range(0, 3)]);
  endtask

  initial begin
    logic [7:0] f[$];
    reset = 1'b1; enable = 1'b1; sel = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_in_ready", a_in_ready, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_last", a_out_last, 0);
    check("reset_out_data", a_out_data, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", a_in_ready, 1);

    make_frame(f, 2, "ab", "xabyab"); run(f, 0, 0, 0);
    make_frame(f, 2, "aa", "aaaa");   run(f, 0, 0, 1);
    make_frame(f, 0, "", "xyz");      run(f, 0, 0, 0);
    make_frame(f, 1, "b", "abba");    run(f, 0, 0, 0);
    make_frame(f, 2, "ab", "abab");   run(f, 0, 5, 0);
    make_frame(f, 2, "AB", "ab");     run(f, 0, 0, 0);
    make_frame(f, 16, "abcdefghijklmnop", "abcdefghijklmnopabcdefghijklmnop"); run(f, 0, 0, 0);
    make_frame(f, 17, "", "abc");     run(f, 0, 0, 0);

    // enable low while a result is pending freezes the output frame
    sel = 1'b0;
    make_frame(f, 1, "a", "aa");
    send_bytes(f, 1'b1, 1'b0);
    enable = 1'b0;
    #1;
    check("disabled_out_valid", ov, 0);
    check("disabled_in_ready", rdy, 0);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    #1;
    recv_result(ref_result(f, 16, 16), 2, 0);

    // reset mid-haystack abandons the frame
    make_frame(f, 1, "a", "aaa");
    send_bytes(f, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midreset_in_ready", rdy, 0);
    check("midreset_out_valid", ov, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("postreset_ready", rdy, 1);
    for (int i = 0; i < 4; i++) begin
      check("postreset_no_output", ov, 0);
      @(negedge clock);
    end
    make_frame(f, 1, "a", "aa"); run(f, 0, 0, 0);

    f = {8'd1, 8'h61};
    for (int i = 0; i < 300; i++) f.push_back(8'h61);
    run(f, 1, 0, 0);
    f = {8'd1, 8'h61};
    for (int i = 0; i < 253; i++) f.push_back(8'h61);
    run(f, 1, 0, 0);
    make_frame(f, 5, "aaaaa", "aaaaa"); run(f, 1, 0, 0);
    make_frame(f, 4, "abab", "ababab"); run(f, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      rand_frame(f, 16);
      run(f, 0, $urandom_range(0, 2), 1);
    end
    for (int t = 0; t < 15; t++) begin
      rand_frame(f, 4);
      run(f, 1, $urandom_range(0, 2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
